// File: rtl/timer_array.sv
// Multi-channel down-counting timer: NCH channels, each with an 8-bit prescaler,
// one-shot/periodic modes and a sticky pending flag, behind one register window.
module timer_array #(
  parameter int NCH   = 2,
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CNT = 2'd2, DONE = 2'd3} state_t;

  // Bus: a write completes in the cycle WE is high; reads are combinational, no wait states.
  logic [3:0] ch;
  logic [1:0] rsel;
  assign ch   = Addr[5:2];
  assign rsel = Addr[1:0];

  state_t           state_q [NCH];
  state_t           state_d [NCH];
  logic [1:0]       mode_q  [NCH];
  logic [7:0]       pre_q   [NCH];
  logic [7:0]       psc_q   [NCH];
  logic [CNT_W-1:0] preset_q[NCH];
  logic [CNT_W-1:0] count_q [NCH];
  logic [NCH-1:0]   en_q, im_q, pend_q;
  logic [NCH-1:0]   wsel, tick, ld, run, dec, expire, stop;

  logic unused_bits;
  assign unused_bits = ^{Addr[29:6], Din};

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      wsel[k] = WE && (ch == 4'(k));
      tick[k] = (psc_q[k] == pre_q[k]);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (reset) state_q[k] <= IDLE;
      else       state_q[k] <= state_d[k];
    end
  end

  // A channel being written holds its FSM for that cycle.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      state_d[k] = state_q[k];
      if (!wsel[k]) begin
        case (state_q[k])
          IDLE: if (en_q[k]) state_d[k] = LOAD;
          LOAD: state_d[k] = CNT;
          CNT: begin
            if (!en_q[k])                                     state_d[k] = IDLE;
            else if (tick[k] && (count_q[k] <= CNT_W'(1)))   state_d[k] = DONE;
          end
          DONE: state_d[k] = (mode_q[k] == 2'b01 && en_q[k]) ? LOAD : IDLE;
          default: state_d[k] = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      ld[k]     = !wsel[k] && (state_q[k] == LOAD);
      run[k]    = !wsel[k] && (state_q[k] == CNT) && en_q[k];
      dec[k]    = run[k] && tick[k] && (count_q[k] > CNT_W'(1));
      expire[k] = run[k] && tick[k] && (count_q[k] <= CNT_W'(1));
      stop[k]   = !wsel[k] && (state_q[k] == DONE) && !(mode_q[k] == 2'b01 && en_q[k]);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (reset) begin
        en_q[k]     <= 1'b0;
        mode_q[k]   <= 2'b00;
        im_q[k]     <= 1'b0;
        pre_q[k]    <= 8'd0;
        preset_q[k] <= '0;
        count_q[k]  <= '0;
        psc_q[k]    <= 8'd0;
        pend_q[k]   <= 1'b0;
      end else if (wsel[k]) begin
        case (rsel)
          2'd0: begin
            en_q[k]   <= Din[0];
            mode_q[k] <= Din[2:1];
            im_q[k]   <= Din[3];
            pre_q[k]  <= Din[15:8];
          end
          2'd1:    preset_q[k] <= Din[CNT_W-1:0];
          2'd3:    if (Din[0]) pend_q[k] <= 1'b0;
          default: ;
        endcase
      end else begin
        if (ld[k]) begin
          count_q[k] <= preset_q[k];
          psc_q[k]   <= 8'd0;
        end
        if (run[k])    psc_q[k]   <= tick[k] ? 8'd0 : psc_q[k] + 8'd1;
        if (dec[k])    count_q[k] <= count_q[k] - CNT_W'(1);
        if (expire[k]) begin
          count_q[k] <= '0;
          pend_q[k]  <= 1'b1;
        end
        if (stop[k])   en_q[k]    <= 1'b0;
      end
    end
  end

  always_comb begin
    Dout = 32'd0;
    for (int k = 0; k < NCH; k++) begin
      if (ch == 4'(k)) begin
        case (rsel)
          2'd0: Dout = {16'd0, pre_q[k], 4'd0, im_q[k], mode_q[k], en_q[k]};
          2'd1: Dout = 32'(preset_q[k]);
          2'd2: Dout = 32'(count_q[k]);
          2'd3: Dout = {31'd0, pend_q[k]};
        endcase
      end
    end
  end

  assign IRQ = |(pend_q & im_q);
endmodule
